// File: rtl/hyperbus_trans_sched_pkg.sv
// Shared types and defaults for the HyperBus transfer scheduler.
package hyperbus_trans_sched_pkg;

    // Default transfer field widths (address, beats-1 length, chip selects).
    localparam int DefNumReq    = 2;
    localparam int DefNumChips  = 2;
    localparam int DefAddrWidth = 32;
    localparam int DefLenWidth  = 16;
    localparam int DefGapWidth  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_e;

    // Index width for an n-entry vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hyperbus_trans_sched_if.sv
// Requester, transfer-channel and completion signals of the scheduler.
interface hyperbus_trans_sched_if
    import hyperbus_trans_sched_pkg::*;
#(
    parameter int NumReq    = DefNumReq,
    parameter int NumChips  = DefNumChips,
    parameter int AddrWidth = DefAddrWidth,
    parameter int LenWidth  = DefLenWidth,
    parameter int GapWidth  = DefGapWidth
);
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq*AddrWidth-1:0] req_addr_i;
    logic [NumReq*LenWidth-1:0]  req_len_i;
    logic [NumReq-1:0]           req_write_i;
    logic [NumReq*NumChips-1:0]  req_cs_i;
    logic                        trans_valid_o;
    logic                        trans_ready_i;
    logic [AddrWidth-1:0]        trans_addr_o;
    logic [LenWidth-1:0]         trans_len_o;
    logic                        trans_write_o;
    logic [NumChips-1:0]         trans_cs_o;
    logic                        rx_hs_i;
    logic                        rx_last_i;
    logic                        b_hs_i;
    logic [GapWidth-1:0]         cfg_idle_gap_i;
    logic [NumReq-1:0]           grant_o;
    logic                        busy_o;
    logic                        err_o;

    // Scheduler side.
    modport slave (
        input  req_valid_i, req_addr_i, req_len_i, req_write_i, req_cs_i,
        input  trans_ready_i, rx_hs_i, rx_last_i, b_hs_i, cfg_idle_gap_i,
        output req_ready_o, trans_valid_o, trans_addr_o, trans_len_o,
        output trans_write_o, trans_cs_o, grant_o, busy_o, err_o
    );

    // Requester / channel side.
    modport master (
        output req_valid_i, req_addr_i, req_len_i, req_write_i, req_cs_i,
        output trans_ready_i, rx_hs_i, rx_last_i, b_hs_i, cfg_idle_gap_i,
        input  req_ready_o, trans_valid_o, trans_addr_o, trans_len_o,
        input  trans_write_o, trans_cs_o, grant_o, busy_o, err_o
    );

endinterface

// File: rtl/hyperbus_trans_sched_rr_pick.sv
// Round-robin first-one finder: lowest set request at or above ptr_i,
// wrapping to the lowest set request overall when none lies above.
module hyperbus_trans_sched_rr_pick #(
    parameter int NumReq = 2,
    parameter int IdxW   = 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] onehot_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    logic [NumReq-1:0] upper;
    logic [NumReq-1:0] cand;

    // Mask off requests below the pointer, fall back to the full set when empty.
    always_comb begin
        upper = {NumReq{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            upper[i] = req_i[i] & (i >= int'(ptr_i));
        end
        cand = (|upper) ? upper : req_i;
    end

    // Lowest set candidate wins; scan downward so the lowest index is written last.
    always_comb begin
        idx_o    = {IdxW{1'b0}};
        onehot_o = {NumReq{1'b0}};
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx_o = cand[i] ? IdxW'(i) : idx_o;
        end
        for (int i = 0; i < NumReq; i++) begin
            onehot_o[i] = cand[i] & (IdxW'(i) == idx_o);
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/hyperbus_trans_sched.sv
// Transfer scheduler: round-robin ownership of the single HyperBus transfer
// channel, one transfer in flight, optional CS-high idle gap afterwards.
module hyperbus_trans_sched
    import hyperbus_trans_sched_pkg::*;
#(
    parameter int NumReq    = DefNumReq,
    parameter int NumChips  = DefNumChips,
    parameter int AddrWidth = DefAddrWidth,
    parameter int LenWidth  = DefLenWidth,
    parameter int GapWidth  = DefGapWidth
) (
    input logic                  clk_i,
    input logic                  rst_i,
    hyperbus_trans_sched_if.slave bus
);

    localparam int IdxW = idx_width(NumReq);

    sched_state_e         state_q, state_d;
    logic [IdxW-1:0]      rr_q, rr_d;
    logic [NumReq-1:0]    grant_q, grant_d;
    logic                 trans_valid_q, trans_valid_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic                 write_q, write_d;
    logic [NumChips-1:0]  cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [GapWidth-1:0]  gap_q, gap_d;

    logic [NumReq-1:0]    pick_onehot;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_any;
    logic [AddrWidth-1:0] sel_addr;
    logic [LenWidth-1:0]  sel_len;
    logic                 sel_write;
    logic [NumChips-1:0]  sel_cs;
    logic                 rx_done_ev;

    hyperbus_trans_sched_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i    (bus.req_valid_i),
        .ptr_i    (rr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign rx_done_ev = bus.rx_hs_i & bus.rx_last_i;

    // Mux the winning requester's fields with an AND-OR over the one-hot pick.
    always_comb begin
        sel_addr  = {AddrWidth{1'b0}};
        sel_len   = {LenWidth{1'b0}};
        sel_write = 1'b0;
        sel_cs    = {NumChips{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            sel_addr  = sel_addr  | (bus.req_addr_i[i*AddrWidth +: AddrWidth] & {AddrWidth{pick_onehot[i]}});
            sel_len   = sel_len   | (bus.req_len_i[i*LenWidth +: LenWidth] & {LenWidth{pick_onehot[i]}});
            sel_write = sel_write | (bus.req_write_i[i] & pick_onehot[i]);
            sel_cs    = sel_cs    | (bus.req_cs_i[i*NumChips +: NumChips] & {NumChips{pick_onehot[i]}});
        end
    end

    // Accept is only offered while idle, and only to the round-robin winner.
    always_comb begin
        if (state_q == IDLE) begin
            bus.req_ready_o = pick_onehot;
        end else begin
            bus.req_ready_o = {NumReq{1'b0}};
        end
    end

    // Scheduler next-state: arbitration, issue, completion tracking and idle gap.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        trans_valid_d = trans_valid_q;
        addr_d        = addr_q;
        len_d         = len_q;
        write_d       = write_q;
        cs_d          = cs_q;
        busy_d        = busy_q;
        gap_d         = gap_q;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = bus.b_hs_i | rx_done_ev;
                if (pick_any) begin
                    addr_d        = sel_addr;
                    len_d         = sel_len;
                    write_d       = sel_write;
                    cs_d          = sel_cs;
                    grant_d       = pick_onehot;
                    rr_d          = (pick_idx == IdxW'(NumReq - 1)) ? {IdxW{1'b0}} : pick_idx + IdxW'(1);
                    trans_valid_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // A completion cannot precede the transfer it completes.
                err_d = bus.b_hs_i | rx_done_ev;
                if (bus.trans_ready_i) begin
                    trans_valid_d = 1'b0;
                    state_d       = WAIT_DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_DONE: begin
                err_d = write_q ? rx_done_ev : bus.b_hs_i;
                if (write_q ? bus.b_hs_i : rx_done_ev) begin
                    grant_d = {NumReq{1'b0}};
                    if (bus.cfg_idle_gap_i != {GapWidth{1'b0}}) begin
                        gap_d   = bus.cfg_idle_gap_i;
                        state_d = GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            GAP: begin
                err_d = bus.b_hs_i | rx_done_ev;
                gap_d = gap_q - GapWidth'(1);
                if (gap_q == GapWidth'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                grant_d       = {NumReq{1'b0}};
                trans_valid_d = 1'b0;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_q          <= {IdxW{1'b0}};
            grant_q       <= {NumReq{1'b0}};
            trans_valid_q <= 1'b0;
            addr_q        <= {AddrWidth{1'b0}};
            len_q         <= {LenWidth{1'b0}};
            write_q       <= 1'b0;
            cs_q          <= {NumChips{1'b0}};
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            gap_q         <= {GapWidth{1'b0}};
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            grant_q       <= grant_d;
            trans_valid_q <= trans_valid_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            write_q       <= write_d;
            cs_q          <= cs_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            gap_q         <= gap_d;
        end
    end

    assign bus.trans_valid_o = trans_valid_q;
    assign bus.trans_addr_o  = addr_q;
    assign bus.trans_len_o   = len_q;
    assign bus.trans_write_o = write_q;
    assign bus.trans_cs_o    = cs_q;
    assign bus.grant_o       = grant_q;
    assign bus.busy_o        = busy_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_hyperbus_trans_sched.sv
// Directed bench for hyperbus_trans_sched with a transfer scoreboard.
module tb_hyperbus_trans_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hyperbus_trans_sched_if #(
        .NumReq(2), .NumChips(2), .AddrWidth(32), .LenWidth(16), .GapWidth(4)
    ) bus ();

    hyperbus_trans_sched #(
        .NumReq(2), .NumChips(2), .AddrWidth(32), .LenWidth(16), .GapWidth(4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
        logic        wr;
        logic [1:0]  cs;
        logic [1:0]  grant;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] f_addr [2];
    logic [15:0] f_len  [2];
    logic        f_wr   [2];
    logic [1:0]  f_cs   [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [15:0] l,
                           input logic w, input logic [1:0] c);
        f_addr[r] = a; f_len[r] = l; f_wr[r] = w; f_cs[r] = c;
        if (r == 0) begin
            bus.req_addr_i[31:0] = a; bus.req_len_i[15:0] = l;
            bus.req_write_i[0] = w;   bus.req_cs_i[1:0] = c;
        end else begin
            bus.req_addr_i[63:32] = a; bus.req_len_i[31:16] = l;
            bus.req_write_i[1] = w;    bus.req_cs_i[3:2] = c;
        end
    endtask

    task automatic push_exp(input int r);
        exp_t e;
        e.addr = f_addr[r]; e.len = f_len[r]; e.wr = f_wr[r]; e.cs = f_cs[r];
        e.grant = (r == 0) ? 2'b01 : 2'b10;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.trans_valid_o), 64'd0);
        check({tag, "_grant"}, 64'(bus.grant_o), 64'd0);
        check({tag, "_busy"},  64'(bus.busy_o), 64'd0);
        check({tag, "_err"},   64'(bus.err_o), 64'd0);
        check({tag, "_cs"},    64'(bus.trans_cs_o), 64'd0);
    endtask

    // Scoreboard monitor: every transfer handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.trans_valid_o && bus.trans_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got addr %0h with no transfer expected", bus.trans_addr_o);
            end else begin
                exp_t e;
                exp_t a;
                e = exp_q.pop_front();
                a.addr = bus.trans_addr_o; a.len = bus.trans_len_o; a.wr = bus.trans_write_o;
                a.cs = bus.trans_cs_o; a.grant = bus.grant_o;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL sb_transfer: got addr %0h len %0d wr %0b cs %b grant %b expected addr %0h len %0d wr %0b cs %b grant %b",
                             a.addr, a.len, a.wr, a.cs, a.grant, e.addr, e.len, e.wr, e.cs, e.grant);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i = 2'b00; bus.req_addr_i = 64'd0; bus.req_len_i = 32'd0;
        bus.req_write_i = 2'b00; bus.req_cs_i = 4'd0; bus.trans_ready_i = 1'b0;
        bus.rx_hs_i = 1'b0; bus.rx_last_i = 1'b0; bus.b_hs_i = 1'b0;
        bus.cfg_idle_gap_i = 4'd0;

        // 1: reset held three cycles, then idle with nothing requested.
        repeat (3) tick();
        check_idle_outputs("rst");
        check("rst_ready", 64'(bus.req_ready_o), 64'd0);
        rst = 1'b0;
        tick(); tick();
        check_idle_outputs("idle");

        // 2: single read from requester 0, eight beats.
        set_req(0, 32'h100, 16'd7, 1'b0, 2'b01);
        bus.req_valid_i = 2'b01;
        #1;
        check("t2_ready", 64'(bus.req_ready_o), 64'b01);
        push_exp(0);
        tick();
        bus.req_valid_i = 2'b00;
        check("t2_valid", 64'(bus.trans_valid_o), 64'd1);
        check("t2_busy", 64'(bus.busy_o), 64'd1);
        bus.trans_ready_i = 1'b1;
        tick();
        bus.trans_ready_i = 1'b0;
        check("t2_valid_drop", 64'(bus.trans_valid_o), 64'd0);
        for (int b = 0; b < 8; b++) begin
            bus.rx_hs_i = 1'b1;
            bus.rx_last_i = (b == 7);
            check("t2_grant_held", 64'(bus.grant_o), 64'b01);
            tick();
        end
        bus.rx_hs_i = 1'b0; bus.rx_last_i = 1'b0;
        check("t2_grant_rel", 64'(bus.grant_o), 64'd0);
        check("t2_busy_rel", 64'(bus.busy_o), 64'd0);
        check("t2_err", 64'(bus.err_o), 64'd0);

        // Reset pulse so round-robin restarts at requester 0.
        rst = 1'b1; tick(); rst = 1'b0;

        // 3: both requesters valid continuously, writes, gap 0.
        set_req(0, 32'h1000, 16'd3, 1'b1, 2'b01);
        set_req(1, 32'h2000, 16'd1, 1'b1, 2'b10);
        bus.req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_ready", 64'(bus.req_ready_o), (k % 2 == 0) ? 64'b01 : 64'b10);
            push_exp(k % 2);
            tick();
            check("t3_grant", 64'(bus.grant_o), (k % 2 == 0) ? 64'b01 : 64'b10);
            bus.trans_ready_i = 1'b1;
            tick();
            bus.trans_ready_i = 1'b0;
            tick();
            bus.b_hs_i = 1'b1;
            tick();
            bus.b_hs_i = 1'b0;
            check("t3_grant_rel", 64'(bus.grant_o), 64'd0);
        end

        // 4: idle gap of 3; cfg changed during the gap must not matter.
        bus.req_valid_i = 2'b01;
        bus.cfg_idle_gap_i = 4'd3;
        #1;
        check("t4_ready", 64'(bus.req_ready_o), 64'b01);
        push_exp(0);
        tick();
        bus.trans_ready_i = 1'b1;
        tick();
        bus.trans_ready_i = 1'b0;
        bus.b_hs_i = 1'b1;
        tick();
        bus.b_hs_i = 1'b0;
        bus.cfg_idle_gap_i = 4'd0;
        for (int g = 0; g < 3; g++) begin
            #1;
            check("t4_gap_busy", 64'(bus.busy_o), 64'd1);
            check("t4_gap_ready", 64'(bus.req_ready_o), 64'd0);
            tick();
        end
        #1;
        check("t4_idle_busy", 64'(bus.busy_o), 64'd0);
        check("t4_idle_ready", 64'(bus.req_ready_o), 64'b01);
        push_exp(0);
        tick();
        bus.req_valid_i = 2'b00;
        check("t4_valid2", 64'(bus.trans_valid_o), 64'd1);
        bus.trans_ready_i = 1'b1;
        tick();
        bus.trans_ready_i = 1'b0;
        bus.b_hs_i = 1'b1;
        tick();
        bus.b_hs_i = 1'b0;
        check("t4_done_idle", 64'(bus.busy_o), 64'd0);

        // 5: stray completions raise err without changing state.
        bus.b_hs_i = 1'b1;
        tick();
        bus.b_hs_i = 1'b0;
        check("t5_err_idle_b", 64'(bus.err_o), 64'd1);
        check("t5_busy_idle", 64'(bus.busy_o), 64'd0);
        tick();
        check("t5_err_clear", 64'(bus.err_o), 64'd0);
        bus.rx_hs_i = 1'b1; bus.rx_last_i = 1'b1;
        tick();
        bus.rx_hs_i = 1'b0; bus.rx_last_i = 1'b0;
        check("t5_err_idle_rx", 64'(bus.err_o), 64'd1);
        set_req(0, 32'h200, 16'd3, 1'b0, 2'b10);
        bus.req_valid_i = 2'b01;
        #1;
        check("t5_ready", 64'(bus.req_ready_o), 64'b01);
        push_exp(0);
        tick();
        bus.req_valid_i = 2'b00;
        bus.trans_ready_i = 1'b1;
        tick();
        bus.trans_ready_i = 1'b0;
        bus.b_hs_i = 1'b1;
        tick();
        bus.b_hs_i = 1'b0;
        check("t5_err_read_b", 64'(bus.err_o), 64'd1);
        check("t5_grant_kept", 64'(bus.grant_o), 64'b01);
        tick();
        check("t5_err_clear2", 64'(bus.err_o), 64'd0);
        for (int b = 0; b < 4; b++) begin
            bus.rx_hs_i = 1'b1;
            bus.rx_last_i = (b == 3);
            tick();
            check("t5_beat_err", 64'(bus.err_o), 64'd0);
        end
        bus.rx_hs_i = 1'b0; bus.rx_last_i = 1'b0;
        check("t5_grant_rel", 64'(bus.grant_o), 64'd0);

        // 6: completion racing the issue handshake, then reset mid-read.
        set_req(0, 32'h300, 16'd3, 1'b0, 2'b10);
        bus.req_valid_i = 2'b01;
        #1;
        check("t6_ready", 64'(bus.req_ready_o), 64'b01);
        push_exp(0);
        tick();
        bus.req_valid_i = 2'b00;
        bus.trans_ready_i = 1'b1; bus.rx_hs_i = 1'b1; bus.rx_last_i = 1'b1;
        tick();
        bus.trans_ready_i = 1'b0; bus.rx_hs_i = 1'b0; bus.rx_last_i = 1'b0;
        check("t6_err_race", 64'(bus.err_o), 64'd1);
        check("t6_grant_race", 64'(bus.grant_o), 64'b01);
        bus.rx_hs_i = 1'b1;
        tick(); tick();
        bus.rx_hs_i = 1'b0;
        check("t6_grant_mid", 64'(bus.grant_o), 64'b01);
        rst = 1'b1;
        tick();
        check_idle_outputs("t6_rst");
        check("t6_addr", 64'(bus.trans_addr_o), 64'd0);
        rst = 1'b0;
        set_req(1, 32'h400, 16'd0, 1'b1, 2'b01);
        bus.req_valid_i = 2'b11;
        #1;
        check("t6_rr_reset", 64'(bus.req_ready_o), 64'b01);
        bus.req_valid_i = 2'b00;
        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
